// File: rtl/bus_arb_pkg.sv
// Shared types and default sizing for the 8088 HOLD/HLDA bus arbiter.
// Optional tenure limiting is enabled by defining HOLD_TENURE_LIMIT_EN.
package bus_arb_pkg;

  localparam int unsigned NreqDefault      = 2;
  localparam int unsigned MaxTenureDefault = 16;

  typedef enum logic [2:0] {
    StIdle,
    StReqHold,
    StGrant,
    StHandoff,
    StRelease
  } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: search starts one past ptr_i and wraps.
// Unaffected by HOLD_TENURE_LIMIT_EN.
module rr_priority_picker #(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic                    valid_o
);

  localparam int unsigned PtrW = $clog2(NREQ);

  logic [PtrW-1:0] idx;

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = PtrW'((32'(ptr_i) + i) % NREQ);
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hold_bus_arbiter.sv
// Arbitrates NREQ bus masters for the 8088 local bus via HOLD/HLDA.
// Define HOLD_TENURE_LIMIT_EN to preempt a tenure after MAX_TENURE grant cycles.
module hold_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned NREQ       = NreqDefault,
  parameter int unsigned MAX_TENURE = MaxTenureDefault
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NREQ-1:0]         REQ,
  output logic [NREQ-1:0]         GNT,
  output logic                    HOLD,
  input  logic                    HLDA,
  output logic [$clog2(NREQ)-1:0] OWNER,
  output logic                    ABORT
);

  localparam int unsigned OwnW = $clog2(NREQ);

  arb_state_e      state_q;
  logic [NREQ-1:0] gnt_q;
  logic            hold_q;
  logic            abort_q;
  logic [OwnW-1:0] owner_q;

  logic [NREQ-1:0] pick_gnt;
  logic            pick_valid;
  logic [OwnW-1:0] pick_idx;
  logic            others_pending;
  logic            ten_expired;

  rr_priority_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req_i   (REQ),
    .ptr_i   (owner_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) pick_idx = OwnW'(i);
    end
  end

  // gnt_q is the owner's one-hot while in GRANT
  assign others_pending = |(REQ & ~gnt_q);

`ifdef HOLD_TENURE_LIMIT_EN
  localparam int unsigned TenW = $clog2(MAX_TENURE + 1);

  logic [TenW-1:0] ten_q;
  logic            enter_grant;

  assign enter_grant = (state_q == StReqHold || state_q == StHandoff) && HLDA && pick_valid;
  assign ten_expired = (state_q == StGrant) && (ten_q == TenW'(MAX_TENURE)) && others_pending;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ten_q <= '0;
    end else if (enter_grant) begin
      ten_q <= TenW'(1);
    end else if (state_q != StGrant) begin
      ten_q <= '0;
    end else if (ten_q != TenW'(MAX_TENURE)) begin
      ten_q <= ten_q + TenW'(1);
    end
  end
`else
  logic unused_max_tenure;
  assign unused_max_tenure = ^MAX_TENURE;
  assign ten_expired       = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      hold_q  <= 1'b0;
      abort_q <= 1'b0;
      owner_q <= OwnW'(NREQ - 1);
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (|REQ) begin
            state_q <= StReqHold;
            hold_q  <= 1'b1;
          end
        end
        StReqHold: begin
          if (HLDA) begin
            if (pick_valid) begin
              state_q <= StGrant;
              gnt_q   <= pick_gnt;
              owner_q <= pick_idx;
            end else begin
              state_q <= StRelease;
              hold_q  <= 1'b0;
            end
          end
        end
        StGrant: begin
          if (!HLDA) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            hold_q  <= 1'b0;
            abort_q <= 1'b1;
          end else if (ten_expired || !REQ[owner_q]) begin
            gnt_q <= '0;
            if (others_pending) begin
              state_q <= StHandoff;
            end else begin
              state_q <= StRelease;
              hold_q  <= 1'b0;
            end
          end
        end
        StHandoff: begin
          if (!HLDA) begin
            state_q <= StIdle;
            hold_q  <= 1'b0;
            abort_q <= 1'b1;
          end else if (pick_valid) begin
            state_q <= StGrant;
            gnt_q   <= pick_gnt;
            owner_q <= pick_idx;
          end else begin
            state_q <= StRelease;
            hold_q  <= 1'b0;
          end
        end
        StRelease: begin
          if (!HLDA) state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          gnt_q   <= '0;
          hold_q  <= 1'b0;
        end
      endcase
    end
  end

  assign GNT   = gnt_q;
  assign HOLD  = hold_q;
  assign ABORT = abort_q;
  assign OWNER = owner_q;

endmodule

// File: tb/tb_hold_bus_arbiter.sv
// Directed bench for hold_bus_arbiter; the tenure section runs when HOLD_TENURE_LIMIT_EN is defined.
module tb_hold_bus_arbiter;

`ifdef HOLD_TENURE_LIMIT_EN
  localparam int unsigned MaxTen = 4;
`else
  localparam int unsigned MaxTen = 16;
`endif

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] REQ;
  logic [1:0] GNT;
  logic       HOLD;
  logic       HLDA;
  logic [0:0] OWNER;
  logic       ABORT;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  hold_bus_arbiter #(
    .NREQ       (2),
    .MAX_TENURE (MaxTen)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .REQ   (REQ),
    .GNT   (GNT),
    .HOLD  (HOLD),
    .HLDA  (HLDA),
    .OWNER (OWNER),
    .ABORT (ABORT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RESET = 1'b1;
    REQ   = 2'b00;
    HLDA  = 1'b0;
    #1;
    check("rst_hold", 32'(HOLD), 0);
    check("rst_gnt", 32'(GNT), 0);
    check("rst_abort", 32'(ABORT), 0);
    check("rst_owner", 32'(OWNER), 1);
    tick();
    tick();
    RESET = 1'b0;

    // Single requester, HLDA arrives late
    REQ = 2'b01;
    tick();
    check("s1_hold_up", 32'(HOLD), 1);
    check("s1_no_gnt", 32'(GNT), 0);
    tick();
    tick();
    tick();
    check("s1_wait_gnt", 32'(GNT), 0);
    HLDA = 1'b1;
    tick();
    check("s1_gnt", 32'(GNT), 32'h1);
    check("s1_owner", 32'(OWNER), 0);
    tick();
    check("s1_gnt_hold", 32'(GNT), 32'h1);
    REQ = 2'b00;
    tick();
    check("s1_rel_hold", 32'(HOLD), 0);
    check("s1_rel_gnt", 32'(GNT), 0);
    REQ = 2'b01;
    tick();
    check("s1_rel_ignore_req", 32'(HOLD), 0);
    HLDA = 1'b0;
    tick();
    check("s1_idle_hold", 32'(HOLD), 0);
    tick();
    check("s1_idle_rereq", 32'(HOLD), 1);

    // Request withdrawn before HLDA
    REQ = 2'b00;
    tick();
    check("s3_hold_kept", 32'(HOLD), 1);
    check("s3_no_gnt", 32'(GNT), 0);
    HLDA = 1'b1;
    tick();
    check("s3_rel_hold", 32'(HOLD), 0);
    check("s3_rel_gnt", 32'(GNT), 0);
    HLDA = 1'b0;
    tick();
    check("s3_idle_hold", 32'(HOLD), 0);

    // Two requesters from reset with a handoff
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    REQ = 2'b11;
    tick();
    check("s2_hold", 32'(HOLD), 1);
    HLDA = 1'b1;
    tick();
    check("s2_gnt0", 32'(GNT), 32'h1);
    check("s2_owner0", 32'(OWNER), 0);
    tick();
    check("s2_gnt0_hold", 32'(GNT), 32'h1);
    REQ = 2'b10;
    tick();
    check("s2_gap_gnt", 32'(GNT), 0);
    check("s2_gap_hold", 32'(HOLD), 1);
    tick();
    check("s2_gnt1", 32'(GNT), 32'h2);
    check("s2_owner1", 32'(OWNER), 1);
    REQ = 2'b11;
    tick();
    check("s2_other_req", 32'(GNT), 32'h2);
`ifndef HOLD_TENURE_LIMIT_EN
    repeat (20) tick();
    check("s2_no_preempt", 32'(GNT), 32'h2);
`endif

    // HLDA lost during GRANT
    HLDA = 1'b0;
    tick();
    check("s4_gnt", 32'(GNT), 0);
    check("s4_hold", 32'(HOLD), 0);
    check("s4_abort", 32'(ABORT), 1);
    tick();
    check("s4_abort_once", 32'(ABORT), 0);
    check("s4_rereq", 32'(HOLD), 1);
    HLDA = 1'b1;
    tick();
    check("s4_wrap_gnt", 32'(GNT), 32'h1);
    check("s4_wrap_owner", 32'(OWNER), 0);

    // Asynchronous reset mid-grant
    RESET = 1'b1;
    #1;
    check("s5_hold", 32'(HOLD), 0);
    check("s5_gnt", 32'(GNT), 0);
    check("s5_abort", 32'(ABORT), 0);
    check("s5_owner", 32'(OWNER), 1);
    tick();
    RESET = 1'b0;
    tick();
    check("s5_rereq", 32'(HOLD), 1);
    tick();
    check("s5_gnt0", 32'(GNT), 32'h1);

    // HLDA lost during HANDOFF
    REQ = 2'b10;
    tick();
    check("s6_gap", 32'(GNT), 0);
    HLDA = 1'b0;
    tick();
    check("s6_hold", 32'(HOLD), 0);
    check("s6_abort", 32'(ABORT), 1);

`ifdef HOLD_TENURE_LIMIT_EN
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    REQ  = 2'b11;
    HLDA = 1'b1;
    tick();
    tick();
    check("t_gnt0_a", 32'(GNT), 32'h1);
    repeat (3) begin
      tick();
      check("t_gnt0_b", 32'(GNT), 32'h1);
    end
    tick();
    check("t_gap0", 32'(GNT), 0);
    repeat (4) begin
      tick();
      check("t_gnt1", 32'(GNT), 32'h2);
    end
    tick();
    check("t_gap1", 32'(GNT), 0);
    tick();
    check("t_gnt0_c", 32'(GNT), 32'h1);
    REQ = 2'b01;
    repeat (10) begin
      tick();
      check("t_solo", 32'(GNT), 32'h1);
    end
    REQ = 2'b11;
    tick();
    check("t_sat_preempt", 32'(GNT), 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/hold_bus_arbiter.md
HOLD_BUS_ARBITER -- requirements
Module: hold_bus_arbiter

Interface
REQ-001 Parameter NREQ, default 2, number of bus-master requesters (2..4).
REQ-002 Parameter MAX_TENURE, default 16, grant-cycle limit per tenure, used only when the tenure feature is compiled in.
REQ-003 CLK  input  1  single clock; all state changes on posedge CLK.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 REQ  input  NREQ  per-requester bus request, level, synchronous to CLK.
REQ-006 GNT  output  NREQ  one-hot-or-zero bus grant, registered.
REQ-007 HOLD  output  1  hold request to the 8088 HOLD pin, registered.
REQ-008 HLDA  input  1  hold acknowledge from the 8088.
REQ-009 OWNER  output  $clog2(NREQ)  index of current or last grantee, registered.
REQ-010 ABORT  output  1  one-cycle pulse when a tenure is killed by HLDA loss.

Function
REQ-011 FSM states SHALL be IDLE, REQ_HOLD, GRANT, HANDOFF and RELEASE.
REQ-012 IDLE: any REQ bit high SHALL move to REQ_HOLD with HOLD=1 on the next edge.
REQ-013 REQ_HOLD: HOLD SHALL stay high until HLDA is sampled high.
REQ-014 On HLDA sampled high, the winner SHALL be picked round-robin among the currently asserted REQ bits, starting at OWNER+1 mod NREQ.
REQ-015 On a pick, GNT[winner] SHALL assert on the next edge, OWNER SHALL update, and the state SHALL become GRANT; HLDA-to-GNT latency is 1 cycle.
REQ-016 If all REQ bits are low when HLDA is sampled high, the FSM SHALL go to RELEASE with no grant.
REQ-017 GRANT: GNT SHALL hold while REQ[OWNER]=1 and HLDA=1; REQ changes from other requesters SHALL not disturb the current grant.
REQ-018 REQ[OWNER] falling with another REQ pending SHALL go to HANDOFF: GNT=0 for exactly one turnaround cycle, HOLD kept high, then a round-robin pick and GRANT.
REQ-019 REQ[OWNER] falling with no REQ pending SHALL go to RELEASE.
REQ-020 RELEASE: HOLD=0 and GNT=0; the FSM SHALL stay in RELEASE until HLDA is sampled low, then go to IDLE; REQ is ignored in RELEASE.
REQ-021 HLDA sampled low in GRANT or HANDOFF SHALL clear GNT and HOLD on the next edge, pulse ABORT for one cycle and go to IDLE.
REQ-022 GNT SHALL never have more than one bit set and SHALL be 0 whenever HOLD=0.
REQ-023 The round-robin pointer SHALL wrap from NREQ-1 to 0.

Reset
REQ-024 While RESET=1: HOLD=0, GNT=0, ABORT=0, OWNER=NREQ-1 (so requester 0 wins first), state IDLE, tenure counter 0.
REQ-025 RESET asserted mid-tenure SHALL clear all outputs immediately (asynchronously), with no ABORT pulse.

Configuration
REQ-026 Macro HOLD_TENURE_LIMIT_EN defined: a counter SHALL count GRANT cycles from 1.
REQ-027 With HOLD_TENURE_LIMIT_EN, when the count reaches MAX_TENURE and another REQ is pending, GNT SHALL drop and the FSM SHALL enter HANDOFF regardless of REQ[OWNER].
REQ-028 With HOLD_TENURE_LIMIT_EN, the counter SHALL saturate at MAX_TENURE when no other REQ is pending.
REQ-029 Macro HOLD_TENURE_LIMIT_EN undefined: there SHALL be no counter and no preemption; a tenure ends only by REQ[OWNER] falling or HLDA loss.

Structure
REQ-030 Package bus_arb_pkg SHALL hold the FSM state enum typedef and the default NREQ/MAX_TENURE constants.
REQ-031 Sub-module rr_priority_picker SHALL be used: combinational, taking REQ and the pointer and returning the one-hot winner and a valid flag.

Verification
REQ-032 REQ=01, HLDA rises 3 cycles after HOLD -> GNT=01 exactly 1 cycle after HLDA is sampled; REQ falls -> HOLD=0 next edge; FSM returns to IDLE after HLDA falls.
REQ-033 REQ=11 from reset -> GNT=01; REQ[0] falls -> 1 cycle GNT=00 with HOLD=1, then GNT=10, OWNER=1.
REQ-034 REQ pulses high then low before HLDA -> RELEASE with no GNT; HOLD drops after HLDA is sampled high.
REQ-035 HLDA forced low during GRANT -> GNT=0 and HOLD=0 next edge; ABORT is high for exactly one cycle.
REQ-036 HOLD_TENURE_LIMIT_EN, MAX_TENURE=4, REQ=11 held -> GNT alternates 01/10 with a 4-cycle tenure and a 1-cycle gap; with REQ=01 only, GNT=01 holds indefinitely.
REQ-037 RESET pulse mid-GRANT -> HOLD=0 and GNT=0 within the same cycle; next grant goes to requester 0.
